frontpanel_spi_device: RTL and testbench

FRONTPANEL_SPI_DEVICE -- requirements
Module: frontpanel_spi_device

---
 rtl/frontpanel_spi_device.sv | 175 +++++++++++++++++
 tb/tb_frontpanel_spi_device.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frontpanel_spi_device.sv
// Front-panel SPI device (mode 0, MSB first). The SCK, CS_N and MOSI pins are
// resynchronised into clk. Edges are found on the synchronised copies. A
// one-byte holding buffer feeds the transmit shifter.
module frontpanel_spi_device #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_start,
  output logic       rx_end,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_underrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_d, r_cs_d;
  logic [SYNC_STAGES:0]   r_flush;
  logic                   r_armed;

  logic [2:0] r_bit_cnt;
  logic       r_first_edge;
  logic [6:0] r_rx_sr;
  logic [7:0] r_tx_sr;
  logic [7:0] r_buf;
  logic       r_buf_full;
  logic       r_miso, r_rx_valid, r_rx_start, r_rx_end, r_underrun;
  logic [7:0] r_rx_data;

  logic       w_sck, w_cs, w_mosi;
  logic       w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic       w_start, w_end, w_rx_shift, w_tx_fall, w_load, w_tx_shift, w_accept;
  logic [7:0] w_tx_next;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  // A CS fall only counts once a real (post-reset) CS high has been seen, so a
  // reset that lands mid-frame cannot fake a new frame start.
  assign w_cs_fall  = r_armed & ~w_cs & r_cs_d;
  assign w_cs_rise  = w_cs & ~r_cs_d;

  assign w_accept = tx_valid & ~r_buf_full;

  // Synchroniser chains, edge-detect delay flops and post-reset CS arming.
  // r_flush marks when the chains hold real pin samples, not reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
      r_flush     <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_sck_sync  <= (r_sck_sync << 1)  | SYNC_STAGES'(spi_sck);
      r_cs_sync   <= (r_cs_sync << 1)   | SYNC_STAGES'(spi_cs_n);
      r_mosi_sync <= (r_mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
      r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      r_armed     <= r_armed | (r_flush[SYNC_STAGES] & w_cs);
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and per-cycle frame events. SCK is ignored in IDLE and in the
  // cycle where CS deasserts.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_end        = 1'b0;
    w_rx_shift   = 1'b0;
    w_tx_fall    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_next = ACTIVE;
          w_start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_state_next = IDLE;
          w_end        = 1'b1;
        end else begin
          w_rx_shift = w_sck_rise;
          w_tx_fall  = w_sck_fall & ~r_first_edge;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_load     = w_start | (w_tx_fall & (r_bit_cnt == 3'd0));
  assign w_tx_shift = w_tx_fall & (r_bit_cnt != 3'd0);

  // Next transmit shifter value. A load takes the buffer, or zero if it is empty.
  always_comb begin
    w_tx_next = r_tx_sr;
    if (w_load)          w_tx_next = r_buf_full ? r_buf : 8'h00;
    else if (w_tx_shift) w_tx_next = {r_tx_sr[6:0], 1'b0};
  end

  // Receive/transmit datapath, holding buffer and output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt    <= 3'd0;
      r_first_edge <= 1'b0;
      r_rx_sr      <= 7'd0;
      r_tx_sr      <= 8'h00;
      r_buf        <= 8'h00;
      r_buf_full   <= 1'b0;
      r_miso       <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_start   <= 1'b0;
      r_rx_end     <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_rx_start <= w_start;
      r_rx_end   <= w_end;
      r_rx_valid <= 1'b0;
      r_underrun <= w_load & ~r_buf_full;
      r_tx_sr    <= w_tx_next;
      r_miso     <= (w_state_next == ACTIVE) & w_tx_next[7];
      // A load empties the buffer; an accept in the same cycle refills it.
      r_buf_full <= (r_buf_full & ~w_load) | w_accept;
      if (w_accept) r_buf <= tx_data;
      if (w_start) begin
        r_bit_cnt    <= 3'd0;
        r_first_edge <= 1'b1;
      end
      if (w_rx_shift) begin
        r_rx_sr      <= {r_rx_sr[5:0], w_mosi};
        r_bit_cnt    <= r_bit_cnt + 3'd1;
        r_first_edge <= 1'b0;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data  <= {r_rx_sr, w_mosi};
          r_rx_valid <= 1'b1;
        end
      end
    end
  end

  assign spi_miso    = r_miso;
  assign rx_valid    = r_rx_valid;
  assign rx_data     = r_rx_data;
  assign rx_start    = r_rx_start;
  assign rx_end      = r_rx_end;
  assign tx_ready    = ~r_buf_full;
  assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_frontpanel_spi_device.sv
// Directed bench for frontpanel_spi_device. SCK runs at clk/8. Inputs change
// 1 ns after the falling clk edge. A negedge monitor counts the output strobes.
module tb_frontpanel_spi_device;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       spi_miso, rx_valid, rx_start, rx_end, tx_ready, tx_underrun;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;

  int n_valid = 0, n_start = 0, n_end = 0, n_under = 0, n_ready = 0, n_mhi = 0;
  int valid_cyc = 0;
  logic [7:0] last_rx = 8'h00;
  int b_valid, b_start, b_end, b_under, b_ready, b_mhi;

  logic [7:0] feed_tab [16];
  logic [3:0] feed_idx = 4'd0;
  logic [3:0] fi;
  logic [7:0] mo;

  assign tx_data = feed_tab[feed_idx];

  frontpanel_spi_device #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_start(rx_start), .rx_end(rx_end),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Present the next table entry once the current one is accepted.
  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      #1 feed_idx = feed_idx + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid   = n_valid + 1;
      last_rx   = rx_data;
      valid_cyc = cyc;
    end
    if (rx_start)    n_start = n_start + 1;
    if (rx_end)      n_end   = n_end + 1;
    if (tx_underrun) n_under = n_under + 1;
    if (tx_ready)    n_ready = n_ready + 1;
    if (spi_miso)    n_mhi   = n_mhi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_valid = n_valid; b_start = n_start; b_end = n_end;
    b_under = n_under; b_ready = n_ready; b_mhi = n_mhi;
  endtask

  task automatic do_reset();
    wait_n(1);
    rst_n = 1'b0;
    #1;
    chk("rst_miso",     32'(spi_miso),    32'd0);
    chk("rst_rx_valid", 32'(rx_valid),    32'd0);
    chk("rst_rx_start", 32'(rx_start),    32'd0);
    chk("rst_rx_end",   32'(rx_end),      32'd0);
    chk("rst_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_rx_data",  32'(rx_data),     32'h00);
    chk("rst_tx_ready", 32'(tx_ready),    32'd1);
    wait_n(2);
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    rst_n    = 1'b1;
    wait_n(8);
  endtask

  // Clocks nbits of d out MSB first and returns the MISO bits seen just before
  // each rising SCK. SCK is left high after the last bit.
  task automatic xfer(input logic [7:0] d, input int nbits, output logic [7:0] miso_bits);
    miso_bits = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = d[7-k];
      wait_n(4);
      miso_bits[7-k] = spi_miso;
      spi_sck  = 1'b1;
      rise_cyc = cyc;
      wait_n(4);
      if (k != nbits - 1) spi_sck = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) feed_tab[i] = 8'h00;

    // Preloaded 0xA5 out, 0x3C in.
    do_reset();
    snap();
    feed_tab[feed_idx] = 8'hA5;
    tx_valid = 1'b1;
    wait_n(1);
    tx_valid = 1'b0;
    chk("t1_ready_full", 32'(tx_ready), 32'd0);
    spi_cs_n = 1'b0;
    wait_n(4);
    chk("t1_start", 32'(n_start - b_start), 32'd1);
    xfer(8'h3C, 8, mo);
    chk("t1_miso_bits", 32'(mo), 32'hA5);
    chk("t1_valid_cnt", 32'(n_valid - b_valid), 32'd1);
    chk("t1_rx_byte",   32'(last_rx), 32'h3C);
    chk("t1_latency",   32'(valid_cyc - rise_cyc), 32'd3);
    chk("t1_no_under",  32'(n_under - b_under), 32'd0);
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    wait_n(6);
    chk("t1_end",       32'(n_end - b_end), 32'd1);
    chk("t1_start_once", 32'(n_start - b_start), 32'd1);
    chk("t1_miso_idle", 32'(spi_miso), 32'd0);

    // No preload: underrun at CS fall and after byte 1.
    do_reset();
    snap();
    spi_cs_n = 1'b0;
    wait_n(4);
    chk("t2_under_start", 32'(n_under - b_under), 32'd1);
    xfer(8'h01, 8, mo);
    chk("t2_miso_b1", 32'(mo), 32'h00);
    chk("t2_rx_b1",   32'(last_rx), 32'h01);
    spi_sck = 1'b0;
    xfer(8'h80, 8, mo);
    chk("t2_miso_b2", 32'(mo), 32'h00);
    chk("t2_under_b1", 32'(n_under - b_under), 32'd2);
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    wait_n(6);
    chk("t2_under_total", 32'(n_under - b_under), 32'd2);
    chk("t2_valid_cnt",   32'(n_valid - b_valid), 32'd2);
    chk("t2_rx_b2",       32'(rx_data), 32'h80);
    chk("t2_miso_never",  32'(n_mhi - b_mhi), 32'd0);

    // tx_valid held across a 3-byte frame.
    do_reset();
    fi = feed_idx;
    feed_tab[fi]        = 8'h11;
    feed_tab[fi + 4'd1] = 8'h22;
    feed_tab[fi + 4'd2] = 8'h33;
    feed_tab[fi + 4'd3] = 8'h44;
    tx_valid = 1'b1;
    wait_n(2);
    snap();
    spi_cs_n = 1'b0;
    wait_n(4);
    xfer(8'h5A, 8, mo);
    chk("t3_miso_b1", 32'(mo), 32'h11);
    spi_sck = 1'b0;
    xfer(8'h5A, 8, mo);
    chk("t3_miso_b2", 32'(mo), 32'h22);
    spi_sck = 1'b0;
    xfer(8'h5A, 8, mo);
    chk("t3_miso_b3", 32'(mo), 32'h33);
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    wait_n(6);
    tx_valid = 1'b0;
    chk("t3_ready_cycles", 32'(n_ready - b_ready), 32'd3);
    chk("t3_no_under",     32'(n_under - b_under), 32'd0);
    chk("t3_ready_full",   32'(tx_ready), 32'd0);
    chk("t3_rx",           32'(rx_data), 32'h5A);

    // CS rises after 5 bits; next frame must start from bit 0.
    do_reset();
    snap();
    spi_cs_n = 1'b0;
    wait_n(4);
    xfer(8'hFF, 5, mo);
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    wait_n(6);
    chk("t4_end_partial",   32'(n_end - b_end), 32'd1);
    chk("t4_no_valid",      32'(n_valid - b_valid), 32'd0);
    chk("t4_rx_unchanged",  32'(rx_data), 32'h00);
    spi_cs_n = 1'b0;
    wait_n(4);
    xfer(8'hFF, 8, mo);
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    wait_n(6);
    chk("t4_valid_full", 32'(n_valid - b_valid), 32'd1);
    chk("t4_rx_ff",      32'(rx_data), 32'hFF);

    // Reset mid-frame with CS held low.
    fi = feed_idx;
    feed_tab[fi]        = 8'hFF;
    feed_tab[fi + 4'd1] = 8'h77;
    tx_valid = 1'b1;
    wait_n(1);
    tx_valid = 1'b0;
    spi_cs_n = 1'b0;
    wait_n(4);
    tx_valid = 1'b1;
    wait_n(1);
    tx_valid = 1'b0;
    xfer(8'hC3, 4, mo);
    chk("t5_pre_miso",  32'(spi_miso), 32'd1);
    chk("t5_pre_ready", 32'(tx_ready), 32'd0);
    snap();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_miso",   32'(spi_miso),    32'd0);
    chk("t5_rst_ready",  32'(tx_ready),    32'd1);
    chk("t5_rst_rxdata", 32'(rx_data),     32'h00);
    chk("t5_rst_valid",  32'(rx_valid),    32'd0);
    chk("t5_rst_end",    32'(rx_end),      32'd0);
    chk("t5_rst_under",  32'(tx_underrun), 32'd0);
    wait_n(2);
    spi_sck = 1'b0;
    rst_n   = 1'b1;
    wait_n(10);
    chk("t5_no_start", 32'(n_start - b_start), 32'd0);
    chk("t5_no_end",   32'(n_end - b_end),     32'd0);
    chk("t5_no_valid", 32'(n_valid - b_valid), 32'd0);
    spi_cs_n = 1'b1;
    wait_n(4);
    spi_cs_n = 1'b0;
    wait_n(4);
    chk("t5_start_after", 32'(n_start - b_start), 32'd1);
    xfer(8'h96, 8, mo);
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    wait_n(6);
    chk("t5_rx",       32'(rx_data), 32'h96);
    chk("t5_valid",    32'(n_valid - b_valid), 32'd1);
    chk("t5_miso_rst", 32'(mo), 32'h00);

    // SCK toggling while CS high, then an empty frame.
    snap();
    for (int i = 0; i < 8; i++) begin
      spi_sck = 1'b1;
      wait_n(4);
      spi_sck = 1'b0;
      wait_n(4);
    end
    chk("t6_no_valid", 32'(n_valid - b_valid), 32'd0);
    chk("t6_no_start", 32'(n_start - b_start), 32'd0);
    chk("t6_no_under", 32'(n_under - b_under), 32'd0);
    chk("t6_miso_low", 32'(n_mhi - b_mhi),     32'd0);
    spi_cs_n = 1'b0;
    wait_n(6);
    spi_cs_n = 1'b1;
    wait_n(6);
    chk("t7_start", 32'(n_start - b_start), 32'd1);
    chk("t7_end",   32'(n_end - b_end),     32'd1);
    chk("t7_valid", 32'(n_valid - b_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
